// File: rtl/qar_gpio_pkg.sv
// qar_gpio_ext shared definitions: register map and interrupt encodings.
// Debounce filter is built only when QAR_GPIO_DEBOUNCE_EN is defined.
package qar_gpio_pkg;

    localparam logic [4:0] ADDR_DIR        = 5'd0;
    localparam logic [4:0] ADDR_OUT        = 5'd1;
    localparam logic [4:0] ADDR_IN         = 5'd2;
    localparam logic [4:0] ADDR_OUT_SET    = 5'd3;
    localparam logic [4:0] ADDR_OUT_CLR    = 5'd4;
    localparam logic [4:0] ADDR_OUT_TGL    = 5'd5;
    localparam logic [4:0] ADDR_IRQ_EN     = 5'd6;
    localparam logic [4:0] ADDR_IRQ_STATUS = 5'd7;
    localparam logic [4:0] ADDR_IRQ_TYPE   = 5'd8;
    localparam logic [4:0] ADDR_IRQ_POL    = 5'd9;
    localparam logic [4:0] ADDR_IRQ_BOTH   = 5'd10;
    localparam logic [4:0] ADDR_ALT_SEL    = 5'd11;
    localparam logic [4:0] ADDR_DB_DIV     = 5'd12;

    localparam logic IRQ_TYPE_EDGE  = 1'b0;
    localparam logic IRQ_TYPE_LEVEL = 1'b1;

    localparam logic POL_RISE = 1'b0;
    localparam logic POL_FALL = 1'b1;
    localparam logic POL_HIGH = 1'b0;
    localparam logic POL_LOW  = 1'b1;

endpackage

// File: rtl/qar_gpio_filter.sv
// Per-pin 2-flop synchronizer with optional debounce filter.
// Debounce (QAR_GPIO_DEBOUNCE_EN): shared prescaler plus 2-bit per-pin counter.
module qar_gpio_filter #(
    parameter int WIDTH = 32,
    parameter int DB_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
`ifdef QAR_GPIO_DEBOUNCE_EN
    input  logic [DB_W-1:0]  db_div,
`endif
    output logic [WIDTH-1:0] filt
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

`ifdef QAR_GPIO_DEBOUNCE_EN
    logic [DB_W-1:0]       pre;
    logic                  tick;
    logic [WIDTH-1:0][1:0] cnt;
    logic [WIDTH-1:0]      filt_q;

    // >= keeps the prescaler sane if DB_DIV is lowered mid-count
    assign tick = (pre >= db_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            filt_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == filt_q[i]) begin
                    cnt[i] <= 2'd0;
                end else if (tick) begin
                    if (cnt[i] == 2'd2) begin
                        filt_q[i] <= sync2[i];
                        cnt[i]    <= 2'd0;
                    end else begin
                        cnt[i] <= cnt[i] + 2'd1;
                    end
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2;
`endif

endmodule

// File: rtl/qar_gpio_ext.sv
// GPIO port: registers, alt-function mux, interrupt detect and read mux.
// Define QAR_GPIO_DEBOUNCE_EN to build the input debounce filter.
module qar_gpio_ext
    import qar_gpio_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_ALT = 2,
    parameter int DB_W    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 write_en,
    input  logic                                 read_en,
    input  logic [4:0]                           addr_word,
    input  logic [31:0]                          wdata,
    output logic [31:0]                          rdata,
    input  logic [WIDTH-1:0]                     gpio_in,
    input  logic [(NUM_ALT > 0 ? NUM_ALT : 1)-1:0] alt_in,
    output logic [WIDTH-1:0]                     gpio_out,
    output logic [WIDTH-1:0]                     gpio_dir,
    output logic                                 irq
);

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_status_q;
    logic [WIDTH-1:0] irq_type_q;
    logic [WIDTH-1:0] irq_pol_q;
    logic [WIDTH-1:0] irq_both_q;
    logic [WIDTH-1:0] alt_sel_q;
`ifdef QAR_GPIO_DEBOUNCE_EN
    logic [DB_W-1:0]  db_div_q;
`endif

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] alt_ext;
    logic [WIDTH-1:0] alt_mask;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] wd;
    logic [31:0]      rd;

    assign wd = wdata[WIDTH-1:0];

    qar_gpio_filter #(
        .WIDTH (WIDTH),
        .DB_W  (DB_W)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .pin_in (gpio_in),
`ifdef QAR_GPIO_DEBOUNCE_EN
        .db_div (db_div_q),
`endif
        .filt   (filt)
    );

    always_comb begin
        alt_ext  = '0;
        alt_mask = '0;
        for (int k = 0; k < NUM_ALT; k++) begin
            alt_ext[k]  = alt_in[k];
            alt_mask[k] = 1'b1;
        end
    end

    assign gpio_out = (alt_sel_q & alt_ext) | (~alt_sel_q & out_q);
    assign gpio_dir = dir_q;
    assign in_val   = (dir_q & gpio_out) | (~dir_q & filt);

    // output pins never raise events; last tracks filt so DIR flips stay silent
    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (irq_type_q[i] == IRQ_TYPE_LEVEL) begin
                ev[i] = (irq_pol_q[i] == POL_LOW) ? ~filt[i] : filt[i];
            end else if (irq_both_q[i]) begin
                ev[i] = filt[i] ^ last_q[i];
            end else if (irq_pol_q[i] == POL_FALL) begin
                ev[i] = last_q[i] & ~filt[i];
            end else begin
                ev[i] = filt[i] & ~last_q[i];
            end
            ev[i] = ev[i] & ~dir_q[i];
        end
    end

    assign w1c = (write_en && addr_word == ADDR_IRQ_STATUS) ? wd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= '0;
            irq_status_q <= '0;
        end else begin
            last_q       <= filt;
            irq_status_q <= (irq_status_q & ~w1c) | ev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q      <= '0;
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_type_q <= '0;
            irq_pol_q  <= '0;
            irq_both_q <= '0;
            alt_sel_q  <= '0;
`ifdef QAR_GPIO_DEBOUNCE_EN
            db_div_q   <= '0;
`endif
        end else if (write_en) begin
            case (addr_word)
                ADDR_DIR:      dir_q      <= wd;
                ADDR_OUT:      out_q      <= wd;
                ADDR_OUT_SET:  out_q      <= out_q | wd;
                ADDR_OUT_CLR:  out_q      <= out_q & ~wd;
                ADDR_OUT_TGL:  out_q      <= out_q ^ wd;
                ADDR_IRQ_EN:   irq_en_q   <= wd;
                ADDR_IRQ_TYPE: irq_type_q <= wd;
                ADDR_IRQ_POL:  irq_pol_q  <= wd;
                ADDR_IRQ_BOTH: irq_both_q <= wd;
                ADDR_ALT_SEL:  alt_sel_q  <= wd & alt_mask;
`ifdef QAR_GPIO_DEBOUNCE_EN
                ADDR_DB_DIV:   db_div_q   <= wdata[DB_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (addr_word)
            ADDR_DIR:        rd[WIDTH-1:0] = dir_q;
            ADDR_OUT:        rd[WIDTH-1:0] = out_q;
            ADDR_IN:         rd[WIDTH-1:0] = in_val;
            ADDR_IRQ_EN:     rd[WIDTH-1:0] = irq_en_q;
            ADDR_IRQ_STATUS: rd[WIDTH-1:0] = irq_status_q;
            ADDR_IRQ_TYPE:   rd[WIDTH-1:0] = irq_type_q;
            ADDR_IRQ_POL:    rd[WIDTH-1:0] = irq_pol_q;
            ADDR_IRQ_BOTH:   rd[WIDTH-1:0] = irq_both_q;
            ADDR_ALT_SEL:    rd[WIDTH-1:0] = alt_sel_q;
`ifdef QAR_GPIO_DEBOUNCE_EN
            ADDR_DB_DIV:     rd[DB_W-1:0]  = db_div_q;
`else
            ADDR_DB_DIV:     rd[DB_W-1:0]  = '0;
`endif
            default: ;
        endcase
    end

    assign rdata = read_en ? rd : 32'd0;
    assign irq   = |(irq_en_q & irq_status_q);

endmodule

// File: tb/tb_qar_gpio_ext.sv
// Directed bench for qar_gpio_ext (WIDTH=16, NUM_ALT=2).
// Debounce-specific vectors run when QAR_GPIO_DEBOUNCE_EN is defined.
module tb_qar_gpio_ext;

    localparam int W = 16;
`ifdef QAR_GPIO_DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [4:0]  addr_word = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [W-1:0] gpio_in = '0;
    logic [1:0]  alt_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_dir;
    logic        irq;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] v;

    qar_gpio_ext #(.WIDTH(W), .NUM_ALT(2), .DB_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .read_en   (read_en),
        .addr_word (addr_word),
        .wdata     (wdata),
        .rdata     (rdata),
        .gpio_in   (gpio_in),
        .alt_in    (alt_in),
        .gpio_out  (gpio_out),
        .gpio_dir  (gpio_dir),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write_en = 1'b1;
        addr_word = a;
        wdata = d;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        read_en = 1'b1;
        addr_word = a;
        #1;
        d = rdata;
        read_en = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // masking and reset behaviour
        rd(5'd0, v);
        check("dir_reset", v, 32'h0);
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, v);
        check("dir_width_mask", v, 32'h0000_FFFF);
        wr(5'd20, 32'h1234_5678);
        rd(5'd20, v);
        check("unmapped_read", v, 32'h0);
        wr(5'd0, 32'h0000_00F0);
        wr(5'd1, 32'h0000_00AA);
        wr(5'd8, 32'h1);
        wr(5'd6, 32'h1);
        gpio_in[0] = 1'b1;
        cyc(8);
        check("level_irq_pre_reset", {31'd0, irq}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_gpio_out", {16'd0, gpio_out}, 32'h0);
        check("reset_gpio_dir", {16'd0, gpio_dir}, 32'h0);
        rd(5'd1, v);
        check("reset_out_reg", v, 32'h0);
        rd(5'd7, v);
        check("reset_status", v, 32'h0);
        gpio_in = '0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // atomic set/clear/toggle
        wr(5'd1, 32'h0000_00F0);
        wr(5'd3, 32'h0000_0003);
        wr(5'd4, 32'h0000_0010);
        wr(5'd5, 32'h0000_0101);
        rd(5'd1, v);
        check("out_atomic", v, 32'h0000_01E2);
        check("gpio_out_atomic", {16'd0, gpio_out}, 32'h0000_01E2);
        wr(5'd1, 32'h0);

        // rising edge latency
        wr(5'd6, 32'h10);
        @(negedge clk);
        gpio_in[4] = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        rd(5'd7, v);
        check("rise_before_latency", v, 32'h0);
        @(posedge clk);
        #1;
        rd(5'd7, v);
        check("rise_status", v, 32'h10);
        check("rise_irq", {31'd0, irq}, 32'h1);
        wr(5'd7, 32'h10);
        rd(5'd7, v);
        check("rise_w1c", v, 32'h0);
        check("rise_irq_clr", {31'd0, irq}, 32'h0);
        wr(5'd6, 32'h0);
        gpio_in[4] = 1'b0;
        cyc(8);
        rd(5'd7, v);
        check("fall_ignored_rise_mode", v, 32'h0);

        // both edges, set wins over simultaneous W1C
        wr(5'd10, 32'h4);
        @(negedge clk);
        gpio_in[2] = 1'b1;
        cyc(LAT - 1);
        wr(5'd7, 32'h4);
        rd(5'd7, v);
        check("both_set_wins", v, 32'h4);
        wr(5'd7, 32'h4);
        rd(5'd7, v);
        check("both_w1c", v, 32'h0);
        gpio_in[2] = 1'b0;
        cyc(8);
        rd(5'd7, v);
        check("both_fall_event", v, 32'h4);
        wr(5'd7, 32'hFFFF_FFFF);

        // level-low sticky while asserted
        wr(5'd8, 32'h8);
        wr(5'd9, 32'h8);
        cyc(2);
        rd(5'd7, v);
        check("level_low_set", v, 32'h8);
        wr(5'd7, 32'h8);
        rd(5'd7, v);
        check("level_low_w1c_held", v, 32'h8);
        gpio_in[3] = 1'b1;
        cyc(8);
        wr(5'd7, 32'h8);
        rd(5'd7, v);
        check("level_low_w1c_ok", v, 32'h0);

        // alt-function mux and output pins
        wr(5'd0, 32'h3);
        wr(5'd11, 32'hFFFF_FFFF);
        rd(5'd11, v);
        check("alt_sel_mask", v, 32'h3);
        wr(5'd11, 32'h1);
        alt_in = 2'b01;
        wr(5'd1, 32'h2);
        #1;
        check("alt_gpio_out", {16'd0, gpio_out}, 32'h3);
        check("alt_gpio_dir", {16'd0, gpio_dir}, 32'h3);
        rd(5'd2, v);
        check("in_alt_hi", v, 32'hB);
        alt_in = 2'b00;
        rd(5'd2, v);
        check("in_alt_lo", v, 32'hA);
        wr(5'd7, 32'hFFFF_FFFF);
        wr(5'd6, 32'h3);
        wr(5'd10, 32'h3);
        gpio_in[1:0] = 2'b11;
        cyc(8);
        rd(5'd7, v);
        check("no_evt_output_pins", v, 32'h0);
        check("no_irq_output_pins", {31'd0, irq}, 32'h0);
        gpio_in[1:0] = 2'b00;
        wr(5'd6, 32'h0);
        cyc(4);
        wr(5'd7, 32'hFFFF_FFFF);

`ifdef QAR_GPIO_DEBOUNCE_EN
        wr(5'd12, 32'h4);
        rd(5'd12, v);
        check("db_div_rw", v, 32'h4);
        @(negedge clk);
        gpio_in[5] = 1'b1;
        cyc(9);
        gpio_in[5] = 1'b0;
        cyc(30);
        rd(5'd7, v);
        check("db_glitch_rejected", v, 32'h0);
        gpio_in[5] = 1'b1;
        cyc(30);
        rd(5'd7, v);
        check("db_stable_event", v, 32'h20);
        rd(5'd2, v);
        check("db_in_follows", v & 32'h20, 32'h20);
`else
        wr(5'd12, 32'h4);
        rd(5'd12, v);
        check("db_div_absent", v, 32'h0);
        @(negedge clk);
        gpio_in[5] = 1'b1;
        @(negedge clk);
        gpio_in[5] = 1'b0;
        cyc(6);
        rd(5'd7, v);
        check("glitch_event", v, 32'h20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
